// File: rtl/my_pkg.sv
// Shared types for the branch target buffer: entry/lookup structs, update record, FSM states.
// BTB_COUNTER_EN selects a 2-bit saturating counter; otherwise CNT[1] holds the last outcome.
package my_pkg;
  localparam int BTB_ENTRIES = 8;
  localparam int BTB_IDX_W   = 3;
  localparam int BTB_TAG_W   = 6;
  localparam int BTB_TA_W    = 32;

  typedef struct packed {
    logic                 v;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_TA_W-1:0]  ta;
    logic                 t;
  } CACHE_BRANCH;

  typedef struct packed {
    logic                 v;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_TA_W-1:0]  ta;
    logic [1:0]           cnt;
  } btb_entry_t;

  typedef struct packed {
    logic [BTB_IDX_W-1:0] idx;
    logic [BTB_TAG_W-1:0] tag;
    logic                 taken;
    logic                 jump;
    logic [BTB_TA_W-1:0]  target;
  } btb_upd_t;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} btb_state_e;

`ifdef BTB_COUNTER_EN
  localparam logic [1:0] CNT_RST = 2'b01;
`else
  // last-outcome mode keeps CNT[0] at zero, including out of reset
  localparam logic [1:0] CNT_RST = 2'b00;
`endif

  // PC[4:2]==101 with PC[7] set is folded onto slot 7 for both lookup and update
  function automatic logic [BTB_IDX_W-1:0] btb_index(input logic [2:0] lo, input logic pc7);
    return (lo == 3'b101 && pc7) ? 3'b111 : lo;
  endfunction
endpackage

// File: rtl/btb_counter.sv
// Next-state logic for an entry's CNT field on a hit.
// BTB_COUNTER_EN: saturating counter; otherwise last-outcome bit in CNT[1].
module btb_counter (
  input  logic [1:0] cnt,
  input  logic       taken,
  input  logic       jump,
  output logic [1:0] cnt_nxt
);
`ifdef BTB_COUNTER_EN
  always_comb begin
    cnt_nxt = cnt;
    if (jump)                  cnt_nxt = 2'b11;
    else if (taken) begin
      if (cnt != 2'b11)        cnt_nxt = cnt + 2'd1;
    end else if (cnt != 2'b00) cnt_nxt = cnt - 2'd1;
  end
`else
  logic cnt_unused;
  assign cnt_unused = ^cnt;
  assign cnt_nxt    = {taken | jump, 1'b0};
`endif
endmodule

// File: rtl/btb_update.sv
// 8-entry flop BTB with a 2-stage update pipe (S1 read+forward, S2 compute+write)
// and an IDLE->DRAIN->FLUSH invalidation sequencer.
module btb_update import my_pkg::*; (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [8:0]  upd_pc,
  input  logic        upd_taken,
  input  logic        upd_jump,
  input  logic [31:0] upd_target,
  input  logic        flush,
  input  logic [5:0]  lk_pc,
  output CACHE_BRANCH lk_out,
  output logic        busy
);
  localparam int STAGES = 2;

  btb_entry_t [BTB_ENTRIES-1:0] entries;
  btb_state_e                   state, state_nxt;
  logic [BTB_IDX_W-1:0]         fcnt, lk_idx;
  logic [STAGES:1]              vld_pipe;
  btb_upd_t                     s1, s2;
  btb_entry_t                   s1_cur, s2_old, s2_new;
  logic [1:0]                   s2_cnt_nxt;
  logic                         accept, s2_hit, lk_unused;

  assign busy      = (state != IDLE);
  assign upd_ready = (state == IDLE) && !flush;
  assign accept    = upd_valid && upd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = DRAIN;
      DRAIN:   if (vld_pipe == '0) state_nxt = FLUSH;
      FLUSH:   if (fcnt == 3'(BTB_ENTRIES-1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // S2's result bypasses the array so back-to-back updates to one slot chain correctly
  assign s1_cur = (vld_pipe[2] && s2.idx == s1.idx) ? s2_new : entries[s1.idx];

  btb_counter u_cnt (.cnt(s2_old.cnt), .taken(s2.taken), .jump(s2.jump), .cnt_nxt(s2_cnt_nxt));

  assign s2_hit = s2_old.v && (s2_old.tag == s2.tag);

  always_comb begin
    s2_new = s2_old;
    if (s2_hit) begin
      s2_new.ta  = s2.target;
      s2_new.cnt = s2_cnt_nxt;
    end else if (s2.taken || s2.jump) begin
      s2_new.v   = 1'b1;
      s2_new.tag = s2.tag;
      s2_new.ta  = s2.target;
      s2_new.cnt = s2.jump ? s2_cnt_nxt : 2'b10;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      fcnt     <= '0;
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      s2_old   <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++)
        entries[i] <= '{v: 1'b0, tag: '0, ta: '0, cnt: CNT_RST};
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept)
        s1 <= '{idx: btb_index(upd_pc[2:0], upd_pc[5]), tag: upd_pc[8:3],
                taken: upd_taken, jump: upd_jump, target: upd_target};
      if (vld_pipe[1]) begin
        s2     <= s1;
        s2_old <= s1_cur;
      end
      if (vld_pipe[2]) entries[s2.idx] <= s2_new;
      if (state == FLUSH) begin
        entries[fcnt].v <= 1'b0;
        fcnt            <= fcnt + 1'b1;
      end
    end
  end

  assign lk_idx    = btb_index(lk_pc[2:0], lk_pc[5]);
  assign lk_unused = ^lk_pc[4:3];

  always_comb begin
    lk_out = '0;
    if (entries[lk_idx].v && !busy)
      lk_out = '{v: 1'b1, tag: entries[lk_idx].tag, ta: entries[lk_idx].ta,
                 t: entries[lk_idx].cnt[1]};
  end
endmodule
